fifo_rd_ctrl: RTL and testbench

//  Read-side controller for the FIFO memory block. Owns the read pointer, drives the

---
 rtl/fifo_rd_ctrl_if.sv | 37 +++
 rtl/fifo_rd_ctrl.sv | 65 ++++++
 tb/tb_fifo_rd_ctrl.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/fifo_rd_ctrl_if.sv
// Read-side FIFO bundle: consumer strobe, pointer exchange with the write side, memory read port, flags.
// The underflow flag exists only when FIFO_RD_UNDERFLOW_EN is defined.
interface fifo_rd_ctrl_if #(
   parameter int DWIDTH = 8,
   parameter int AWIDTH = 4
);
   logic              readN;
   logic [AWIDTH:0]   wr_ptr;
   logic [AWIDTH-1:0] rd_addr;
   logic [DWIDTH-1:0] mem_data;
   logic [AWIDTH:0]   rd_ptr;
   logic [DWIDTH-1:0] data_out;
   logic              data_valid;
   logic              empty;
   logic              almost_empty;
   logic [AWIDTH:0]   fill_level;
`ifdef FIFO_RD_UNDERFLOW_EN
   logic              underflow;
`endif

   // master: the read controller; slave: write side, memory and consumer around it
   modport master (
      input  readN, wr_ptr, mem_data,
      output rd_addr, rd_ptr, data_out, data_valid, empty, almost_empty, fill_level
`ifdef FIFO_RD_UNDERFLOW_EN
      , output underflow
`endif
   );

   modport slave (
      output readN, wr_ptr, mem_data,
      input  rd_addr, rd_ptr, data_out, data_valid, empty, almost_empty, fill_level
`ifdef FIFO_RD_UNDERFLOW_EN
      , input underflow
`endif
   );
endinterface

// File: rtl/fifo_rd_ctrl.sv
// FIFO read controller: owns rd_ptr, registers the read word one cycle after an accepted readN; reads on
// empty are dropped and never stall. FIFO_RD_UNDERFLOW_EN adds a sticky underflow flag.
module fifo_rd_ctrl #(
   parameter int DWIDTH    = 8,
   parameter int AWIDTH    = 4,
   parameter int AE_THRESH = 2
) (
   input  logic           clk,
   input  logic           rstN,
   fifo_rd_ctrl_if.master bus
);
   localparam logic [AWIDTH:0] PTR_ONE  = (AWIDTH+1)'(1);
   localparam logic [AWIDTH:0] AE_LEVEL = (AWIDTH+1)'(AE_THRESH);

   logic [AWIDTH:0]   rd_ptr_q;
   logic [DWIDTH-1:0] data_q;
   logic              valid_q;
   logic [AWIDTH:0]   fill;
   logic              is_empty;
   logic              accept;

   // Modular difference of wrap-bit pointers: equal means empty, MSB-only difference means full.
   always_comb begin
      fill     = bus.wr_ptr - rd_ptr_q;
      is_empty = (fill == '0);
      accept   = !bus.readN && !is_empty;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         rd_ptr_q <= '0;
         data_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         valid_q <= accept;
         if (accept) begin
            data_q   <= bus.mem_data;
            rd_ptr_q <= rd_ptr_q + PTR_ONE;
         end
      end
   end

`ifdef FIFO_RD_UNDERFLOW_EN
   logic uflow_q;

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         uflow_q <= 1'b0;
      end else if (!bus.readN && is_empty) begin
         uflow_q <= 1'b1;
      end
   end

   assign bus.underflow = uflow_q;
`endif

   // Address comes straight from the pointer flop so the memory sees no combinational glitches.
   assign bus.rd_addr      = rd_ptr_q[AWIDTH-1:0];
   assign bus.rd_ptr       = rd_ptr_q;
   assign bus.data_out     = data_q;
   assign bus.data_valid   = valid_q;
   assign bus.empty        = is_empty;
   assign bus.almost_empty = (fill <= AE_LEVEL);
   assign bus.fill_level   = fill;
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: the bench plays write side and memory, checks outputs on the falling edge.
// Underflow checks are included when FIFO_RD_UNDERFLOW_EN is defined.
module tb_fifo_rd_ctrl;
   localparam int DW = 8;
   localparam int AW = 4;

   logic clk;
   logic rstN;
   int   n_checks;
   int   n_fails;

   logic [DW-1:0] mem [16];
   logic [DW-1:0] exp_q [16];

   fifo_rd_ctrl_if #(.DWIDTH(DW), .AWIDTH(AW)) bus ();

   fifo_rd_ctrl #(.DWIDTH(DW), .AWIDTH(AW), .AE_THRESH(2)) dut (
      .clk  (clk),
      .rstN (rstN),
      .bus  (bus)
   );

   assign bus.mem_data = mem[bus.rd_addr];

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      n_checks = 0;
      n_fails  = 0;
      for (int i = 0; i < 16; i++) mem[i] = '0;
      rstN       = 1'b0;
      bus.readN  = 1'b1;
      bus.wr_ptr = '0;

      // reset state
      #12;
      check("rst_rd_ptr", 32'(bus.rd_ptr), 32'd0);
      check("rst_dv", 32'(bus.data_valid), 32'd0);
      check("rst_dout", 32'(bus.data_out), 32'd0);
      check("rst_empty", 32'(bus.empty), 32'd1);
      check("rst_ae", 32'(bus.almost_empty), 32'd1);
      check("rst_fill", 32'(bus.fill_level), 32'd0);
`ifdef FIFO_RD_UNDERFLOW_EN
      check("rst_uflow", 32'(bus.underflow), 32'd0);
`endif
      @(negedge clk);
      rstN = 1'b1;

      // single read
      mem[0]     = 8'hA5;
      bus.wr_ptr = 5'd1;
      @(negedge clk);
      check("single_empty_before", 32'(bus.empty), 32'd0);
      bus.readN = 1'b0;
      @(negedge clk);
      check("single_dout", 32'(bus.data_out), 32'hA5);
      check("single_dv", 32'(bus.data_valid), 32'd1);
      check("single_rd_ptr", 32'(bus.rd_ptr), 32'd1);
      check("single_empty", 32'(bus.empty), 32'd1);
      bus.readN = 1'b1;
      @(negedge clk);
      check("single_dv_drop", 32'(bus.data_valid), 32'd0);
      check("single_dout_hold", 32'(bus.data_out), 32'hA5);

      // thresholds: drain from fill 4 to 0
      for (int i = 1; i <= 4; i++) mem[i] = 8'(8'h40 + i);
      bus.wr_ptr = 5'd5;
      @(negedge clk);
      check("thr_fill4", 32'(bus.fill_level), 32'd4);
      check("thr_ae4", 32'(bus.almost_empty), 32'd0);
      check("thr_empty4", 32'(bus.empty), 32'd0);
      bus.readN = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         @(negedge clk);
         check("thr_dout", 32'(bus.data_out), 32'(8'h40 + k));
         check("thr_fill", 32'(bus.fill_level), 32'(4 - k));
         check("thr_ae", 32'(bus.almost_empty), (4 - k) <= 2 ? 32'd1 : 32'd0);
         check("thr_empty", 32'(bus.empty), k == 4 ? 32'd1 : 32'd0);
      end
      bus.readN = 1'b1;
      @(negedge clk);
      check("pre_rst_rd_ptr", 32'(bus.rd_ptr), 32'd5);

      // asynchronous reset mid-stream, with a read pending
      bus.wr_ptr = 5'd6;
      bus.readN  = 1'b0;
      #2;
      rstN       = 1'b0;
      bus.wr_ptr = '0;
      #1;
      check("arst_rd_ptr", 32'(bus.rd_ptr), 32'd0);
      check("arst_dv", 32'(bus.data_valid), 32'd0);
      check("arst_dout", 32'(bus.data_out), 32'd0);
      check("arst_empty", 32'(bus.empty), 32'd1);
      bus.readN = 1'b1;
      @(negedge clk);
      rstN = 1'b1;

      // burst of 16 then wrap
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 16; i++) begin
            exp_q[i] = (pass == 0) ? 8'(i * 7 + 3) : (8'hF0 ^ 8'(i));
            mem[i]   = exp_q[i];
         end
         bus.wr_ptr = (pass == 0) ? 5'd16 : 5'd0;
         @(negedge clk);
         check("burst_fill16", 32'(bus.fill_level), 32'd16);
         check("burst_empty0", 32'(bus.empty), 32'd0);
         bus.readN = 1'b0;
         for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            check("burst_dout", 32'(bus.data_out), 32'(exp_q[k]));
            check("burst_dv", 32'(bus.data_valid), 32'd1);
         end
         bus.readN = 1'b1;
         check("burst_rd_ptr", 32'(bus.rd_ptr), (pass == 0) ? 32'd16 : 32'd0);
         check("burst_rd_addr", 32'(bus.rd_addr), 32'd0);
         check("burst_empty", 32'(bus.empty), 32'd1);
         @(negedge clk);
         check("burst_dv_end", 32'(bus.data_valid), 32'd0);
      end

      // read on empty at wr_ptr == rd_ptr == 3
      mem[0] = 8'h11;
      mem[1] = 8'h22;
      mem[2] = 8'h33;
      bus.wr_ptr = 5'd3;
      bus.readN  = 1'b0;
      repeat (3) @(negedge clk);
      check("emp_rd_ptr_reach", 32'(bus.rd_ptr), 32'd3);
      check("emp_last_dout", 32'(bus.data_out), 32'h33);
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         check("emp_dv", 32'(bus.data_valid), 32'd0);
         check("emp_rd_ptr", 32'(bus.rd_ptr), 32'd3);
         check("emp_dout_hold", 32'(bus.data_out), 32'h33);
`ifdef FIFO_RD_UNDERFLOW_EN
         check("emp_uflow", 32'(bus.underflow), 32'd1);
`endif
      end
      bus.readN = 1'b1;
      repeat (2) @(negedge clk);
`ifdef FIFO_RD_UNDERFLOW_EN
      check("uflow_sticky", 32'(bus.underflow), 32'd1);
`endif
      check("emp_rd_ptr_idle", 32'(bus.rd_ptr), 32'd3);

      // simultaneous write and read keeps fill at 3
      mem[3] = 8'h5A;
      mem[4] = 8'h6B;
      mem[5] = 8'h7C;
      bus.wr_ptr = 5'd6;
      @(negedge clk);
      check("sim_fill_before", 32'(bus.fill_level), 32'd3);
      bus.readN = 1'b0;
      @(posedge clk);
      #1;
      mem[6]     = 8'h8D;
      bus.wr_ptr = 5'd7;
      bus.readN  = 1'b1;
      @(negedge clk);
      check("sim_fill", 32'(bus.fill_level), 32'd3);
      check("sim_dv", 32'(bus.data_valid), 32'd1);
      check("sim_dout", 32'(bus.data_out), 32'h5A);
      check("sim_rd_ptr", 32'(bus.rd_ptr), 32'd4);
      @(negedge clk);
      check("sim_dv_drop", 32'(bus.data_valid), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
      $finish;
   end
endmodule
